pcileech_tlps128_cfgspace_completer: RTL and testbench

TLP-side counterpart of the shadow configuration space. It accepts configuration request TLPs that the PCIe core forwards to the user application, drives one read or write request into the shadow cfgspace port, and waits for the shadow's response. It then emits the matching Cpl or CplD completion TLP on the 128-bit TX stream. At most one request is outstanding at a time.

---
 rtl/pcileech_tlps128_cfgspace_completer.sv | 205 ++++++++++++++++++++
 tb/tb_pcileech_tlps128_cfgspace_completer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_tlps128_cfgspace_completer.sv
// Config-request TLP completer: forwards CfgRd0/CfgWr0 to the shadow
// cfgspace and returns the matching Cpl/CplD on the 128-bit TX stream.

module pcileech_tlps128_cfgspace_completer #(
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [15:0]  pcie_id,
   input  logic         in_valid,
   input  logic [127:0] in_data,
   output logic         in_ready,
   output logic         shadow_rx_rden,
   output logic         shadow_rx_wren,
   output logic [3:0]   shadow_rx_be,
   output logic [9:0]   shadow_rx_addr,
   output logic [31:0]  shadow_rx_data,
   output logic [7:0]   shadow_rx_tag,
   input  logic         shadow_tx_valid,
   input  logic         shadow_tx_tlprd,
   input  logic [7:0]   shadow_tx_tag,
   input  logic [31:0]  shadow_tx_data,
   output logic         out_valid,
   output logic [127:0] out_data,
   output logic [3:0]   out_keep,
   input  logic         out_ready,
   output logic [15:0]  stat_rd_cnt,
   output logic [15:0]  stat_wr_cnt,
   output logic [15:0]  stat_err_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, CPL} state_e;

   localparam logic [2:0] ST_SC    = 3'b000;
   localparam logic [2:0] ST_UR    = 3'b001;
   localparam logic [2:0] ST_CA    = 3'b100;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e         state_q;
   logic           in_ready_q;
   logic           rden_q;
   logic           wren_q;
   logic [3:0]     be_q;
   logic [9:0]     addr_q;
   logic [31:0]    wdata_q;
   logic [7:0]     tag_q;
   logic [15:0]    rid_q;
   logic           is_rd_q;
   logic [7:0]     tmo_q;
   logic           out_valid_q;
   logic [127:0]   out_data_q;
   logic [3:0]     out_keep_q;
   logic [15:0]    rd_cnt_q;
   logic [15:0]    wr_cnt_q;
   logic [15:0]    err_cnt_q;

   logic [1:0]     fmt;
   logic [4:0]     typ;
   logic [9:0]     len;
   logic           fmt_ok;
   logic           is_cfg;
   logic           is_req;
   logic           is_ur;
   logic           accept;
   logic           pending;
   logic           match;
   logic           stray;
   logic           timeout;
   logic [15:0]    err_inc_d;
   logic           unused_ok;

   assign fmt     = in_data[30:29];
   assign typ     = in_data[28:24];
   assign len     = in_data[9:0];
   assign fmt_ok  = (fmt == 2'b00) || (fmt == 2'b10);
   assign is_cfg  = fmt_ok && (typ == 5'b00100 || typ == 5'b00101);
   assign is_req  = fmt_ok && typ == 5'b00100 && len == 10'd1;
   assign is_ur   = is_cfg && !is_req;
   assign accept  = in_valid && in_ready_q && state_q == IDLE;

   // The write ack arrives in the same cycle as wren, so REQ also matches.
   assign pending = state_q == REQ || state_q == WAIT;
   assign match   = pending && shadow_tx_valid &&
                    shadow_tx_tag == tag_q &&
                    shadow_tx_tlprd == is_rd_q;
   assign stray   = shadow_tx_valid && !match;
   assign timeout = state_q == WAIT && !match && tmo_q == TMO_LAST;

   assign err_inc_d = {15'd0, (accept && !is_req) || timeout}
                    + {15'd0, stray};

   assign unused_ok = ^{in_data[31], in_data[23:10], in_data[39:36],
                        in_data[65:64], in_data[95:76]};

   function automatic logic [127:0] cpl_tlp(
      input logic        cpld,
      input logic [2:0]  st,
      input logic [15:0] cid,
      input logic [15:0] rid,
      input logic [7:0]  tag,
      input logic [31:0] d
   );
      logic [31:0] dw0;
      dw0 = {1'b0, cpld, 1'b0, 5'b01010, 14'd0, 9'd0, cpld};
      return {cpld ? d : 32'd0, rid, tag, 8'd0,
              cid, st, 1'b0, 12'd4, dw0};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         rden_q      <= 1'b0;
         wren_q      <= 1'b0;
         be_q        <= 4'd0;
         addr_q      <= 10'd0;
         wdata_q     <= 32'd0;
         tag_q       <= 8'd0;
         rid_q       <= 16'd0;
         is_rd_q     <= 1'b0;
         tmo_q       <= 8'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 128'd0;
         out_keep_q  <= 4'd0;
         rd_cnt_q    <= 16'd0;
         wr_cnt_q    <= 16'd0;
         err_cnt_q   <= 16'd0;
      end else begin
         rden_q    <= 1'b0;
         wren_q    <= 1'b0;
         err_cnt_q <= err_cnt_q + err_inc_d;
         if (match && is_rd_q)
            rd_cnt_q <= rd_cnt_q + 16'd1;
         if (match && !is_rd_q)
            wr_cnt_q <= wr_cnt_q + 16'd1;
         unique case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (accept && (is_req || is_ur)) begin
                  in_ready_q <= 1'b0;
                  rid_q      <= in_data[63:48];
                  tag_q      <= in_data[47:40];
                  is_rd_q    <= fmt == 2'b00;
               end
               if (accept && is_req) begin
                  state_q <= REQ;
                  rden_q  <= fmt == 2'b00;
                  wren_q  <= fmt == 2'b10;
                  be_q    <= in_data[35:32];
                  addr_q  <= {in_data[75:72], in_data[71:66]};
                  wdata_q <= in_data[127:96];
               end else if (accept && is_ur) begin
                  state_q     <= CPL;
                  out_valid_q <= 1'b1;
                  out_keep_q  <= 4'b0111;
                  out_data_q  <= cpl_tlp(1'b0, ST_UR, pcie_id,
                                         in_data[63:48],
                                         in_data[47:40], 32'd0);
               end
            end
            REQ, WAIT: begin
               if (match) begin
                  state_q     <= CPL;
                  out_valid_q <= 1'b1;
                  out_keep_q  <= is_rd_q ? 4'b1111 : 4'b0111;
                  out_data_q  <= cpl_tlp(is_rd_q, ST_SC, pcie_id,
                                         rid_q, tag_q, shadow_tx_data);
               end else if (timeout) begin
                  state_q     <= CPL;
                  out_valid_q <= 1'b1;
                  out_keep_q  <= 4'b0111;
                  out_data_q  <= cpl_tlp(1'b0, ST_CA, pcie_id,
                                         rid_q, tag_q, 32'd0);
               end else begin
                  state_q <= WAIT;
                  tmo_q   <= (state_q == REQ) ? 8'd0 : tmo_q + 8'd1;
               end
            end
            CPL: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready       = in_ready_q;
   assign shadow_rx_rden = rden_q;
   assign shadow_rx_wren = wren_q;
   assign shadow_rx_be   = be_q;
   assign shadow_rx_addr = addr_q;
   assign shadow_rx_data = wdata_q;
   assign shadow_rx_tag  = tag_q;
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_keep       = out_keep_q;
   assign stat_rd_cnt    = rd_cnt_q;
   assign stat_wr_cnt    = wr_cnt_q;
   assign stat_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pcileech_tlps128_cfgspace_completer.sv
// Bench for the cfgspace completer: behavioural shadow stand-in plus a
// reference memory and completion builder derived from the TLP rules.

module tb_pcileech_tlps128_cfgspace_completer;

   localparam int          TMO     = 16;
   localparam logic [15:0] PCIE_ID = 16'h1A2B;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid, in_ready;
   logic [127:0] in_data;
   logic         shadow_rx_rden, shadow_rx_wren;
   logic [3:0]   shadow_rx_be;
   logic [9:0]   shadow_rx_addr;
   logic [31:0]  shadow_rx_data;
   logic [7:0]   shadow_rx_tag;
   logic         shadow_tx_valid, shadow_tx_tlprd;
   logic [7:0]   shadow_tx_tag;
   logic [31:0]  shadow_tx_data;
   logic         out_valid, out_ready;
   logic [127:0] out_data;
   logic [3:0]   out_keep;
   logic [15:0]  stat_rd_cnt, stat_wr_cnt, stat_err_cnt;

   int          checks = 0;
   int          passes = 0;
   logic [15:0] e_rd = 0, e_wr = 0, e_err = 0;
   logic [31:0] rmem [1024];

   // shadow stand-in controls
   logic        auto_en = 1'b1;
   logic        seed_load = 1'b1;
   logic        inj_v = 1'b0, inj_rd = 1'b0;
   logic [7:0]  inj_tag = 8'd0;
   logic [31:0] inj_d = 32'd0;
   logic [31:0] smem [1024];
   logic        p1 = 1'b0, p2 = 1'b0;
   logic [7:0]  t1 = 8'd0, t2 = 8'd0;
   logic [31:0] d1 = 32'd0, d2 = 32'd0;

   always #5 clk = ~clk;

   pcileech_tlps128_cfgspace_completer #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .pcie_id(PCIE_ID),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .shadow_rx_rden(shadow_rx_rden), .shadow_rx_wren(shadow_rx_wren),
      .shadow_rx_be(shadow_rx_be), .shadow_rx_addr(shadow_rx_addr),
      .shadow_rx_data(shadow_rx_data), .shadow_rx_tag(shadow_rx_tag),
      .shadow_tx_valid(shadow_tx_valid), .shadow_tx_tlprd(shadow_tx_tlprd),
      .shadow_tx_tag(shadow_tx_tag), .shadow_tx_data(shadow_tx_data),
      .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
      .out_ready(out_ready),
      .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt),
      .stat_err_cnt(stat_err_cnt)
   );

   function automatic logic [31:0] seed(int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // shadow: 2-cycle read pipeline, combinational write acknowledge
   always @(posedge clk) begin
      if (seed_load) begin
         for (int i = 0; i < 1024; i++) smem[i] <= seed(i);
      end else if (shadow_rx_wren) begin
         for (int b = 0; b < 4; b++)
            if (shadow_rx_be[b])
               smem[shadow_rx_addr][8*b +: 8] <= shadow_rx_data[8*b +: 8];
      end
      p1 <= shadow_rx_rden & auto_en;
      t1 <= shadow_rx_tag;
      d1 <= smem[shadow_rx_addr];
      p2 <= p1;
      t2 <= t1;
      d2 <= d1;
   end

   always_comb begin
      shadow_tx_valid = 1'b0;
      shadow_tx_tlprd = 1'b0;
      shadow_tx_tag   = 8'd0;
      shadow_tx_data  = 32'd0;
      if (inj_v) begin
         shadow_tx_valid = 1'b1;
         shadow_tx_tlprd = inj_rd;
         shadow_tx_tag   = inj_tag;
         shadow_tx_data  = inj_d;
      end else if (p2) begin
         shadow_tx_valid = 1'b1;
         shadow_tx_tlprd = 1'b1;
         shadow_tx_tag   = t2;
         shadow_tx_data  = d2;
      end else if (auto_en && shadow_rx_wren) begin
         shadow_tx_valid = 1'b1;
         shadow_tx_tag   = shadow_rx_tag;
      end
   end

   // kinds: 0 CfgRd0, 1 CfgWr0, 2 CfgRd1, 3 CfgWr1, 4 Type0 len 2, 5 MemRd
   function automatic logic [127:0] make_tlp(
      int kind, logic [15:0] rid, logic [7:0] tag, logic [3:0] ext,
      logic [5:0] rg, logic [3:0] be, logic [31:0] d);
      logic [1:0] fmt;
      logic [4:0] typ;
      logic [9:0] len;
      fmt = 2'b00;
      typ = 5'b00100;
      len = 10'd1;
      case (kind)
         1: fmt = 2'b10;
         2: typ = 5'b00101;
         3: begin fmt = 2'b10; typ = 5'b00101; end
         4: len = 10'd2;
         5: typ = 5'b00000;
         default: ;
      endcase
      return {d, 20'h0, ext, rg, 2'b00, rid, tag, 4'h0, be,
              1'b0, fmt, typ, 14'h0, len};
   endfunction

   function automatic logic [127:0] exp_cpl(
      bit cpld, logic [2:0] st, logic [15:0] rid, logic [7:0] tag,
      logic [31:0] d);
      logic [31:0] w0, w1, w2, w3;
      w0 = cpld ? 32'h4A000001 : 32'h0A000000;
      w1 = (32'(PCIE_ID) << 16) | (32'(st) << 13) | 32'd4;
      w2 = (32'(rid) << 16) | (32'(tag) << 8);
      w3 = cpld ? d : 32'd0;
      return {w3, w2, w1, w0};
   endfunction

   task automatic apply_wr(logic [9:0] a, logic [3:0] be, logic [31:0] d);
      for (int b = 0; b < 4; b++)
         if (be[b]) rmem[a][8*b +: 8] = d[8*b +: 8];
   endtask

   // returns at the negedge of cycle T+1 (accept at end of cycle T)
   task automatic send_req(logic [127:0] d);
      int n = 0;
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!in_ready) $display("FAIL accept_wait in_ready=%b required 1", in_ready);
      else passes++;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_txn(int kind, logic [15:0] rid, logic [7:0] tag,
                         logic [3:0] ext, logic [5:0] rg, logic [3:0] be,
                         logic [31:0] d, bit silent);
      logic [9:0]   a;
      int           k, lat, nrd, nwr;
      bit           sbad, cpld;
      logic [2:0]   st;
      logic [127:0] ex;
      a    = {ext, rg};
      nrd  = 0;
      nwr  = 0;
      sbad = 1'b0;
      auto_en = !silent;
      send_req(make_tlp(kind, rid, tag, ext, rg, be, d));
      if (kind == 5) begin
         for (int i = 0; i < 6; i++) begin
            if (out_valid || shadow_rx_rden || shadow_rx_wren || !in_ready)
               sbad = 1'b1;
            @(negedge clk);
         end
         checks++;
         if (sbad) $display("FAIL drop out_valid/strobe/in_ready seen=%b required 0", sbad);
         else passes++;
         e_err++;
      end else begin
         for (k = 1; k < 300; k++) begin
            if (shadow_rx_rden) begin
               nrd++;
               if (k != 1 || shadow_rx_addr !== a || shadow_rx_tag !== tag)
                  sbad = 1'b1;
            end
            if (shadow_rx_wren) begin
               nwr++;
               if (k != 1 || shadow_rx_addr !== a || shadow_rx_tag !== tag ||
                   shadow_rx_be !== be || shadow_rx_data !== d)
                  sbad = 1'b1;
            end
            if (out_valid) break;
            @(negedge clk);
         end
         cpld = kind == 0 && !silent;
         lat  = kind == 0 ? (silent ? 2 + TMO : 4) : (kind == 1 ? 2 : 1);
         st   = kind <= 1 ? (silent ? 3'b100 : 3'b000) : 3'b001;
         ex   = exp_cpl(cpld, st, rid, tag, rmem[a]);
         checks++;
         if (nrd != int'(kind == 0) || nwr != int'(kind == 1) || sbad)
            $display("FAIL strobe kind=%0d rd=%0d wr=%0d bad=%b required rd=%0d wr=%0d bad=0",
                     kind, nrd, nwr, sbad, kind == 0, kind == 1);
         else passes++;
         checks++;
         if (k != lat) $display("FAIL latency kind=%0d got T+%0d required T+%0d", kind, k, lat);
         else passes++;
         checks++;
         if (out_data !== ex || out_keep !== (cpld ? 4'hF : 4'h7))
            $display("FAIL cpl kind=%0d data=%h keep=%h required %h keep=%h",
                     kind, out_data, out_keep, ex, cpld ? 4'hF : 4'h7);
         else passes++;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL handshake out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
         else passes++;
         if (kind == 1) apply_wr(a, be, d);
         if (cpld) e_rd++;
         else if (kind == 1) e_wr++;
         else e_err++;
      end
      checks++;
      if (stat_rd_cnt !== e_rd || stat_wr_cnt !== e_wr || stat_err_cnt !== e_err)
         $display("FAIL counters kind=%0d rd/wr/err=%0d/%0d/%0d required %0d/%0d/%0d",
                  kind, stat_rd_cnt, stat_wr_cnt, stat_err_cnt, e_rd, e_wr, e_err);
      else passes++;
      auto_en = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      seed_load = 1'b0;
      checks++;
      if (in_ready !== 0 || out_valid !== 0 || out_data !== 0 || out_keep !== 0 ||
          shadow_rx_rden !== 0 || shadow_rx_wren !== 0 || shadow_rx_be !== 0 ||
          shadow_rx_addr !== 0 || shadow_rx_data !== 0 || shadow_rx_tag !== 0)
         $display("FAIL reset_outputs in_ready=%b out_valid=%b keep=%h addr=%h required all 0",
                  in_ready, out_valid, out_keep, shadow_rx_addr);
      else passes++;
      checks++;
      if (stat_rd_cnt !== 0 || stat_wr_cnt !== 0 || stat_err_cnt !== 0)
         $display("FAIL reset_counters %0d/%0d/%0d required 0/0/0",
                  stat_rd_cnt, stat_wr_cnt, stat_err_cnt);
      else passes++;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b required 1", in_ready);
      else passes++;
   endtask

   task automatic test_cfgrd;
      do_txn(1, 16'h0100, 8'h11, 4'h0, 6'h01, 4'hF, 32'h00100406, 1'b0);
      do_txn(0, 16'h0100, 8'h2A, 4'h0, 6'h01, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic test_cfgwr;
      do_txn(1, 16'h0200, 8'h33, 4'h1, 6'h3F, 4'hC, 32'hDEADBEEF, 1'b0);
      do_txn(0, 16'h0200, 8'h34, 4'h1, 6'h3F, 4'h0, 32'h0, 1'b0);
      do_txn(1, 16'h0200, 8'h35, 4'h1, 6'h3F, 4'h0, 32'h12345678, 1'b0);
   endtask

   task automatic test_ur_drop;
      do_txn(2, 16'h0300, 8'h40, 4'h0, 6'h02, 4'hF, 32'h0, 1'b0);
      do_txn(3, 16'h0301, 8'h41, 4'h2, 6'h05, 4'hF, 32'hCAFE0001, 1'b0);
      do_txn(4, 16'h0302, 8'h42, 4'h0, 6'h06, 4'hF, 32'h0, 1'b0);
      do_txn(5, 16'h0303, 8'h43, 4'h0, 6'h07, 4'hF, 32'h0, 1'b0);
   endtask

   task automatic test_timeout;
      do_txn(0, 16'h0400, 8'h55, 4'h3, 6'h10, 4'h0, 32'h0, 1'b1);
      inj_v = 1'b1; inj_rd = 1'b1; inj_tag = 8'h55; inj_d = 32'h1;
      @(negedge clk);
      inj_v = 1'b0;
      @(negedge clk);
      e_err++;
      checks++;
      if (out_valid !== 1'b0 || stat_err_cnt !== e_err)
         $display("FAIL late_resp out_valid=%b err=%0d required 0/%0d",
                  out_valid, stat_err_cnt, e_err);
      else passes++;
   endtask

   task automatic test_backpressure;
      logic [127:0] held, ex;
      int           k;
      bit           bad;
      bad = 1'b0;
      out_ready = 1'b0;
      send_req(make_tlp(1, 16'h0500, 8'h66, 4'h0, 6'h09, 4'h3, 32'hA5A5C3C3));
      for (k = 1; k < 20 && !out_valid; k++) @(negedge clk);
      ex = exp_cpl(1'b0, 3'b000, 16'h0500, 8'h66, 32'h0);
      checks++;
      if (k != 2 || out_data !== ex || out_keep !== 4'h7)
         $display("FAIL bp_cpl T+%0d data=%h required T+2 %h", k, out_data, ex);
      else passes++;
      held = out_data;
      in_data  = make_tlp(0, 16'h0501, 8'h67, 4'h0, 6'h09, 4'h0, 32'h0);
      in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!out_valid || out_data !== held || in_ready || shadow_rx_rden)
            bad = 1'b1;
      end
      checks++;
      if (bad) $display("FAIL bp_hold unstable=%b required 0", bad);
      else passes++;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bp_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      else passes++;
      apply_wr(10'h009, 4'h3, 32'hA5A5C3C3);
      e_wr++;
      do_txn(0, 16'h0501, 8'h67, 4'h0, 6'h09, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic test_stray;
      logic [7:0]  t;
      logic [31:0] dd;
      int          k;
      t  = 8'($urandom);
      dd = $urandom;
      auto_en = 1'b0;
      send_req(make_tlp(0, 16'h0600, t, 4'h5, 6'h21, 4'h0, 32'h0));
      for (k = 1; k < 40; k++) begin
         inj_v   = (k == 3 || k == 4 || k == 6);
         inj_tag = (k == 3) ? (t ^ 8'h01) : t;
         inj_rd  = (k != 4);
         inj_d   = dd;
         if (out_valid) break;
         @(negedge clk);
      end
      inj_v = 1'b0;
      checks++;
      if (k != 7 || out_data !== exp_cpl(1'b1, 3'b000, 16'h0600, t, dd) || out_keep !== 4'hF)
         $display("FAIL stray_cpl T+%0d data=%h required T+7 %h",
                  k, out_data, exp_cpl(1'b1, 3'b000, 16'h0600, t, dd));
      else passes++;
      @(negedge clk);
      auto_en = 1'b1;
      e_err += 16'd2;
      e_rd++;
      checks++;
      if (stat_rd_cnt !== e_rd || stat_err_cnt !== e_err)
         $display("FAIL stray_counters rd=%0d err=%0d required %0d/%0d",
                  stat_rd_cnt, stat_err_cnt, e_rd, e_err);
      else passes++;
   endtask

   task automatic test_reset_mid;
      auto_en = 1'b0;
      send_req(make_tlp(0, 16'h0700, 8'h77, 4'h0, 6'h0A, 4'h0, 32'h0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 0 || out_valid !== 0 || out_data !== 0 || out_keep !== 0 ||
          shadow_rx_rden !== 0 || shadow_rx_wren !== 0 || shadow_rx_addr !== 0 ||
          shadow_rx_tag !== 0 || stat_rd_cnt !== 0 || stat_wr_cnt !== 0 ||
          stat_err_cnt !== 0)
         $display("FAIL mid_reset in_ready=%b out_valid=%b tag=%h err=%0d required all 0",
                  in_ready, out_valid, shadow_rx_tag, stat_err_cnt);
      else passes++;
      rst = 1'b0;
      e_rd = 0; e_wr = 0; e_err = 0;
      @(negedge clk);
      inj_v = 1'b1; inj_rd = 1'b1; inj_tag = 8'h77; inj_d = 32'h0;
      @(negedge clk);
      inj_v = 1'b0;
      e_err = 1;
      checks++;
      if (stat_err_cnt !== e_err || out_valid !== 1'b0)
         $display("FAIL post_reset_stray err=%0d out_valid=%b required 1/0",
                  stat_err_cnt, out_valid);
      else passes++;
      auto_en = 1'b1;
      do_txn(0, 16'h0701, 8'h78, 4'h0, 6'h0A, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++)
         do_txn($urandom_range(0, 5), 16'($urandom), 8'($urandom),
                4'($urandom), 6'($urandom), 4'($urandom), $urandom, 1'b0);
   endtask

   initial begin
      in_valid  = 1'b0;
      in_data   = 128'd0;
      out_ready = 1'b1;
      for (int i = 0; i < 1024; i++) rmem[i] = seed(i);
      test_reset();
      test_cfgrd();
      test_cfgwr();
      test_ur_drop();
      test_timeout();
      test_backpressure();
      test_stray();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
